// File: rtl/rx_pkg.sv
// Shared definitions for the rx sample window controller.
// Holds the default geometry (sample width, buffer depth, address width)
// and the sweep state machine encodings used by the controller.
package rx_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned DEFAULT_DEPTH      = 510;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 9;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/rx_sample_ram.sv
// Simple dual-port sample RAM, read-first, one-cycle registered read.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (read register only)
//   we, waddr, wdata  write port
//   re, raddr, rdata  read port; rdata updates one edge after re and holds otherwise
module rx_sample_ram
  import rx_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The array itself is never reset; only the output register is.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Non-blocking read of the array gives read-first behaviour on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/rx_sample_window_controller.sv
// Multi-channel circular sample buffer controller for the receive path.
// Writes store one NUM_CH-wide word per enabled cycle into a DEPTH-entry ring;
// a sweep plays back the most recent min(sweep_len, fill) words, oldest first.
// Ports:
//   crx_clk, rrx_rst_n    clock, asynchronous active-low reset
//   erx_en                global enable; low freezes everything and masks qualifiers
//   wr_en, wr_data        sample write (ch0 in the LSBs)
//   sweep_start, sweep_len  window playback request and requested length
//   rd_data, rd_valid, rd_first, rd_last  playback stream (1-cycle RAM latency)
//   busy                  sweep FSM is in ST_SWEEP
//   fill_count            stored entries, saturating at DEPTH
module rx_sample_window_controller
  import rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_CH     = 1,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                         crx_clk,
  input  logic                         rrx_rst_n,
  input  logic                         erx_en,
  input  logic                         wr_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
  input  logic                         sweep_start,
  input  logic [ADDR_WIDTH-1:0]        sweep_len,
  output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
  output logic                         rd_valid,
  output logic                         rd_first,
  output logic                         rd_last,
  output logic                         busy,
  output logic [ADDR_WIDTH-1:0]        fill_count
);

  // One extra bit so a count of exactly DEPTH (up to 2^ADDR_WIDTH) and the
  // wrap arithmetic for the start address never overflow.
  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] LastC  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] OneC   = CW'(1);

  sweep_state_e  state_q, state_d;
  logic [CW-1:0] wp_q, wp_d;
  logic [CW-1:0] fill_q, fill_d;
  logic [CW-1:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0] remain_q, remain_d;
  logic          first_q, first_d;

  logic          wr_fire;
  logic          accept;
  logic          issue;
  logic [CW-1:0] len_req;
  logic [CW-1:0] win_len;
  logic [CW-1:0] start_addr;

  // Read qualifiers delayed to line up with the registered RAM output.
  logic          pipe_valid_q;
  logic          pipe_first_q;
  logic          pipe_last_q;

  // Write pointer, fill tracking and window geometry.
  always_comb begin
    wr_fire = erx_en & wr_en;
    wp_d    = wp_q;
    fill_d  = fill_q;
    if (wr_fire) begin
      wp_d = (wp_q == LastC) ? '0 : wp_q + OneC;
      if (fill_q != DepthC) begin
        fill_d = fill_q + OneC;
      end
    end
    // Post-write pointer and fill make a same-cycle write the newest sample.
    len_req    = CW'(sweep_len);
    win_len    = (len_req < fill_d) ? len_req : fill_d;
    start_addr = (wp_d >= win_len) ? wp_d - win_len : wp_d + DepthC - win_len;
    accept     = erx_en & sweep_start & (win_len != '0);
    issue      = erx_en & (state_q == ST_SWEEP);
  end

  // Sweep FSM next state; an accepted start overrides an in-progress sweep.
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    remain_d  = remain_q;
    first_d   = first_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SWEEP;
          rd_addr_d = start_addr;
          remain_d  = win_len;
          first_d   = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (accept) begin
          rd_addr_d = start_addr;
          remain_d  = win_len;
          first_d   = 1'b1;
        end else if (issue) begin
          rd_addr_d = (rd_addr_q == LastC) ? '0 : rd_addr_q + OneC;
          remain_d  = remain_q - OneC;
          first_d   = 1'b0;
          if (remain_q == OneC) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      state_q   <= ST_IDLE;
      wp_q      <= '0;
      fill_q    <= '0;
      rd_addr_q <= '0;
      remain_q  <= '0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      fill_q    <= fill_d;
      rd_addr_q <= rd_addr_d;
      remain_q  <= remain_d;
      first_q   <= first_d;
    end
  end

  // Frozen while disabled so an in-flight read is re-presented on resume.
  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      pipe_valid_q <= 1'b0;
      pipe_first_q <= 1'b0;
      pipe_last_q  <= 1'b0;
    end else if (erx_en) begin
      pipe_valid_q <= issue;
      pipe_first_q <= issue & first_q;
      pipe_last_q  <= issue & (remain_q == OneC);
    end
  end

  rx_sample_ram #(
    .WIDTH      (NUM_CH * DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (crx_clk),
    .rst_n (rrx_rst_n),
    .we    (wr_fire),
    .waddr (ADDR_WIDTH'(wp_q)),
    .wdata (wr_data),
    .re    (issue),
    .raddr (ADDR_WIDTH'(rd_addr_q)),
    .rdata (rd_data)
  );

  always_comb begin
    rd_valid   = pipe_valid_q & erx_en;
    rd_first   = pipe_first_q & erx_en;
    rd_last    = pipe_last_q & erx_en;
    busy       = (state_q == ST_SWEEP);
    fill_count = fill_q[ADDR_WIDTH-1:0];
  end

endmodule
